// File: rtl/dmux_stream.sv
// dmux_stream: registered 1-to-NUM_OUT stream demultiplexer with broadcast.
//
// A single holding stage takes one word from the producer and offers it to
// the addressed channel, or to every channel on broadcast. The word is held
// until every addressed consumer has taken it. Each consumer may take it on
// a different cycle.
//
// Ports:
//   CLK        system clock, rising edge
//   RESET      asynchronous active-high reset
//   IN_DATA    input payload
//   IN_SEL     destination channel index
//   IN_BCAST   1 = deliver to all channels, IN_SEL ignored
//   IN_VALID   producer has a word
//   IN_READY   stage accepts a word this cycle
//   OUT_DATA   held payload, shared by all channels
//   OUT_VALID  bit i = channel i has a pending word
//   OUT_READY  bit i = consumer i takes the word this cycle
//   ERR_SEL    sticky: an out-of-range IN_SEL was dropped
//   ERR_CLR    synchronous clear of ERR_SEL (a same-cycle drop wins)
module dmux_stream #(
    parameter int WIDTH   = 16,
    parameter int NUM_OUT = 8,
    parameter int SEL_W   = 3
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [WIDTH-1:0]   IN_DATA,
    input  logic [SEL_W-1:0]   IN_SEL,
    input  logic               IN_BCAST,
    input  logic               IN_VALID,
    output logic               IN_READY,
    output logic [WIDTH-1:0]   OUT_DATA,
    output logic [NUM_OUT-1:0] OUT_VALID,
    input  logic [NUM_OUT-1:0] OUT_READY,
    output logic               ERR_SEL,
    input  logic               ERR_CLR
);

    // One extra bit so that NUM_OUT itself is representable when NUM_OUT
    // is an exact power of two.
    localparam logic [SEL_W:0] NUM_OUT_L = (SEL_W + 1)'(NUM_OUT);

    logic [WIDTH-1:0]   data_p0;
    logic [NUM_OUT-1:0] pend_p0;
    logic               err_sel_q;

    logic [NUM_OUT-1:0] pend_next;
    logic [NUM_OUT-1:0] sel_onehot;
    logic               accept;
    logic               sel_ok;
    logic               drop;

    // Channels whose consumer takes the word this cycle drop out of the
    // pending mask. The stage is free as soon as nothing would remain
    // pending, which lets a new word load on the cycle the last one drains.
    always_comb begin
        pend_next  = pend_p0 & ~OUT_READY;
        IN_READY   = (pend_next == '0);
        accept     = IN_VALID & IN_READY;
        sel_ok     = ({1'b0, IN_SEL} < NUM_OUT_L);
        drop       = accept & ~IN_BCAST & ~sel_ok;
        sel_onehot = {{(NUM_OUT - 1){1'b0}}, 1'b1} << IN_SEL;
    end

    // ---- stage p0: holding register and pending mask ----
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            data_p0   <= '0;
            pend_p0   <= '0;
            err_sel_q <= 1'b0;
        end else begin
            if (accept) begin
                if (IN_BCAST) begin
                    data_p0 <= IN_DATA;
                    pend_p0 <= '1;
                end else if (sel_ok) begin
                    data_p0 <= IN_DATA;
                    pend_p0 <= sel_onehot;
                end else begin
                    // Out-of-range destination: consume the word and discard it,
                    // leaving the held data untouched.
                    pend_p0 <= '0;
                end
            end else begin
                pend_p0 <= pend_next;
            end

            // Set has priority so that a drop is never lost to a concurrent clear.
            if (drop) begin
                err_sel_q <= 1'b1;
            end else if (ERR_CLR) begin
                err_sel_q <= 1'b0;
            end
        end
    end

    assign OUT_DATA  = data_p0;
    assign OUT_VALID = pend_p0;
    assign ERR_SEL   = err_sel_q;

endmodule
